// File: rtl/irq_pending_latch.sv
// Request front-end for the 8-input priority encoder: synchronises raw request lines,
// latches rising edges into sticky pending bits, gates them by mask and retires by index.

module irq_pending_lane #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_clr_hit,
  input  logic i_ovf_clr,
  output logic o_pend,
  output logic o_ovf
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_d;
  logic                   r_pend;
  logic                   r_ovf;
  logic                   w_rise;

  assign w_rise = r_sync[SYNC_STAGES-1] & ~r_d;

  // A fresh edge always wins over a same-cycle clear; overflow only counts
  // edges that land on a bit that stays pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
      r_d    <= 1'b0;
      r_pend <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_req};
      r_d    <= r_sync[SYNC_STAGES-1];
      r_pend <= w_rise | (r_pend & ~i_clr_hit);
      r_ovf  <= (w_rise & r_pend & ~i_clr_hit) | (r_ovf & ~i_ovf_clr);
    end
  end

  assign o_pend = r_pend;
  assign o_ovf  = r_ovf;

endmodule

module irq_pending_latch #(
  parameter int N           = 8,
  parameter int IDX_W       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_in,
  input  logic [N-1:0]     mask,
  input  logic             clr_valid,
  input  logic [IDX_W-1:0] clr_idx,
  input  logic             ovf_clr,
  output logic [N-1:0]     pending,
  output logic [N-1:0]     enc_in,
  output logic             irq,
  output logic [N-1:0]     overflow
);

  logic [N-1:0] w_clr_hit;
  logic         r_irq;

  // Out-of-range indices match no lane, so they are ignored for free.
  for (genvar g = 0; g < N; g++) begin : g_lane
    assign w_clr_hit[g] = clr_valid && (clr_idx == IDX_W'(g));

    irq_pending_lane #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .i_req    (req_in[g]),
      .i_clr_hit(w_clr_hit[g]),
      .i_ovf_clr(ovf_clr),
      .o_pend   (pending[g]),
      .o_ovf    (overflow[g])
    );
  end

  assign enc_in = pending & mask;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_irq <= 1'b0;
    else      r_irq <= |enc_in;
  end

  assign irq = r_irq;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Bench for irq_pending_latch: directed vector table, corner sequences, then random
// traffic compared against a delay-line reference model.

module tb_irq_pending_latch;

  localparam int N = 8;
  localparam int S = 2;

  logic       clk;
  logic       rst;
  logic [7:0] req_in;
  logic [7:0] mask;
  logic       clr_valid;
  logic [2:0] clr_idx;
  logic       ovf_clr;
  logic [7:0] pending;
  logic [7:0] enc_in;
  logic       irq;
  logic [7:0] overflow;

  irq_pending_latch #(.N(N), .IDX_W(3), .SYNC_STAGES(S)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_in   (req_in),
    .mask     (mask),
    .clr_valid(clr_valid),
    .clr_idx  (clr_idx),
    .ovf_clr  (ovf_clr),
    .pending  (pending),
    .enc_in   (enc_in),
    .irq      (irq),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Reference model: hist[j] is req_in sampled j+1 edges ago.
  logic [7:0] hist[$];
  logic [7:0] m_pend, m_ovf;
  logic       m_irq;

  task automatic model_reset();
    hist.delete();
    for (int j = 0; j <= S; j++) hist.push_back(8'h00);
    m_pend = 8'h00;
    m_ovf  = 8'h00;
    m_irq  = 1'b0;
  endtask

  task automatic model_update();
    logic [7:0] rise, np, no;
    rise = hist[S-1] & ~hist[S];
    for (int i = 0; i < N; i++) begin
      bit hit;
      hit = clr_valid && (int'(clr_idx) == i);
      np[i] = rise[i] ? 1'b1 : (hit ? 1'b0 : m_pend[i]);
      no[i] = (rise[i] && m_pend[i] && !hit) ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf[i]);
    end
    m_irq  = |(m_pend & mask);
    m_pend = np;
    m_ovf  = no;
    hist.push_front(req_in);
    void'(hist.pop_back());
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step_n(input int n);
    for (int j = 0; j < n; j++) step();
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] req;
    logic [7:0] msk;
    logic       cv;
    logic [2:0] ci;
    logic       oc;
    logic [7:0] pend;
    logic [7:0] enc;
    logic       irq;
    logic [7:0] ovf;
  } vec_t;

  vec_t tbl[18];

  initial begin
    logic [7:0] prev_pend;

    // expectations hold just after the edge that consumes the row's inputs
    tbl[0]  = '{8'h08, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    tbl[1]  = '{8'h08, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    tbl[2]  = '{8'h08, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h08, 8'h08, 1'b0, 8'h00};
    tbl[3]  = '{8'h08, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h08, 8'h08, 1'b1, 8'h00};
    tbl[4]  = '{8'h08, 8'hFF, 1'b1, 3'd3, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00};
    tbl[5]  = '{8'h08, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    tbl[6]  = '{8'h4C, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    tbl[7]  = '{8'h4C, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    tbl[8]  = '{8'h4C, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h44, 8'h44, 1'b0, 8'h00};
    tbl[9]  = '{8'h4C, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h44, 8'h44, 1'b1, 8'h00};
    tbl[10] = '{8'h4C, 8'hFF, 1'b1, 3'd6, 1'b0, 8'h04, 8'h04, 1'b1, 8'h00};
    tbl[11] = '{8'h4C, 8'hFF, 1'b1, 3'd2, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00};
    tbl[12] = '{8'h4C, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    tbl[13] = '{8'h5C, 8'hEF, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    tbl[14] = '{8'h5C, 8'hEF, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    tbl[15] = '{8'h5C, 8'hEF, 1'b0, 3'd0, 1'b0, 8'h10, 8'h00, 1'b0, 8'h00};
    tbl[16] = '{8'h5C, 8'hEF, 1'b0, 3'd0, 1'b0, 8'h10, 8'h00, 1'b0, 8'h00};
    tbl[17] = '{8'h5C, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h10, 8'h10, 1'b1, 8'h00};

    rst = 1'b0; req_in = 8'h00; mask = 8'hFF;
    clr_valid = 1'b0; clr_idx = 3'd0; ovf_clr = 1'b0;
    model_reset();
    #12;
    chk("rst_pending", pending, 8'h00);
    chk("rst_enc", enc_in, 8'h00);
    chk("rst_irq", {7'd0, irq}, 8'h00);
    chk("rst_ovf", overflow, 8'h00);
    @(negedge clk);
    rst = 1'b1;

    // Tests 1-3: latency, multi-request clear, mask gating
    prev_pend = 8'h00;
    for (int i = 0; i < 18; i++) begin
      req_in = tbl[i].req; mask = tbl[i].msk;
      clr_valid = tbl[i].cv; clr_idx = tbl[i].ci; ovf_clr = tbl[i].oc;
      #1;
      chk($sformatf("v%0d_enc_pre", i), enc_in, prev_pend & tbl[i].msk);
      step();
      chk($sformatf("v%0d_pending", i), pending, tbl[i].pend);
      chk($sformatf("v%0d_enc", i), enc_in, tbl[i].enc);
      chk($sformatf("v%0d_irq", i), {7'd0, irq}, {7'd0, tbl[i].irq});
      chk($sformatf("v%0d_ovf", i), overflow, tbl[i].ovf);
      prev_pend = tbl[i].pend;
    end
    clr_valid = 1'b0;

    // Test 4: overflow on re-edge of an already-pending line
    req_in = 8'h5D; step_n(3);
    chk("t4_pend0", pending, 8'h11);
    req_in = 8'h5C; step_n(3);
    req_in = 8'h5D; step_n(3);
    chk("t4_ovf_set", overflow, 8'h01);
    chk("t4_pend_held", pending, 8'h11);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("t4_ovf_clr", overflow, 8'h00);

    // Test 5: set beats clear, first on an idle bit then on a pending one
    req_in = 8'h7D; step_n(2);
    clr_valid = 1'b1; clr_idx = 3'd5; step(); clr_valid = 1'b0;
    chk("t5_pend", pending, 8'h31);
    chk("t5_ovf", overflow, 8'h00);
    req_in = 8'h5D; step_n(3);
    req_in = 8'h7D; step_n(2);
    clr_valid = 1'b1; clr_idx = 3'd5; step(); clr_valid = 1'b0;
    chk("t5b_pend", pending, 8'h31);
    chk("t5b_ovf", overflow, 8'h00);

    // Test 6: asynchronous reset mid-operation
    req_in = 8'h00; step_n(3);
    for (int i = 0; i < N; i++) begin
      clr_valid = 1'b1; clr_idx = 3'(i); step();
    end
    clr_valid = 1'b0;
    chk("t6_cleared", pending, 8'h00);
    req_in = 8'hA5; step_n(3);
    chk("t6_pend", pending, 8'hA5);
    req_in = 8'hA4; step_n(3);
    req_in = 8'hA5; step_n(3);
    chk("t6_ovf", overflow, 8'h01);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_pend", pending, 8'h00);
    chk("t6_rst_ovf", overflow, 8'h00);
    chk("t6_rst_enc", enc_in, 8'h00);
    chk("t6_rst_irq", {7'd0, irq}, 8'h00);
    model_reset();
    req_in = 8'h80; mask = 8'hFF;
    @(negedge clk);
    rst = 1'b1;
    // the first edge after release starts the synchroniser
    step();
    chk("t6_rel_e1", pending, 8'h00);
    step_n(2);
    chk("t6_rel_e3", pending, 8'h80);

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 3) == 0) req_in[b] = ~req_in[b];
      mask      = 8'($urandom);
      clr_valid = 1'($urandom_range(0, 1));
      clr_idx   = 3'($urandom_range(0, 7));
      ovf_clr   = ($urandom_range(0, 15) == 0);
      step();
      chk($sformatf("r%0d_pending", c), pending, m_pend);
      chk($sformatf("r%0d_ovf", c), overflow, m_ovf);
      chk($sformatf("r%0d_irq", c), {7'd0, irq}, {7'd0, m_irq});
      chk($sformatf("r%0d_enc", c), enc_in, m_pend & mask);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
